// File: rtl/golden_nonce_reporter.sv
`default_nettype none
// ============================================================================
// Module      : golden_nonce_reporter
// Description : Captures golden-nonce hits from the miner core into a small
//               FIFO and serializes each one as a 5-byte record
//               (SYNC_BYTE, nonce[31:24], [23:16], [15:8], [7:0]) on a
//               valid/ready byte stream. Hits arriving while the FIFO is full
//               are dropped and counted.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               nonce_valid/in  - one-cycle hit pulse and 32-bit nonce
//               out_valid/data  - registered output byte stream
//               out_ready       - sink accept
//               busy            - FIFO not empty or record in flight
//               fifo_count      - entries stored (0..DEPTH)
//               drop_count      - saturating count of dropped hits
//               overflow        - sticky drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module golden_nonce_reporter #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nonce_valid,
    input  logic [31:0]                nonce_in,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [7:0]                 drop_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_B3   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_B1   = 3'd4;
    localparam logic [2:0] S_B0   = 3'd5;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    drop_q;
    logic          ovf_q;

    logic w_full, w_push, w_drop, w_accept, w_pop, w_nonempty;

    // Full is taken from the registered count, so a same-cycle pop never
    // makes room for a hit arriving at that edge.
    assign w_full     = (count_q == CW'(DEPTH));
    assign w_nonempty = (count_q != '0);
    assign w_push     = nonce_valid && !w_full && !rst;
    assign w_drop     = nonce_valid &&  w_full;
    assign w_accept   = out_valid_q && out_ready;
    assign count_d    = count_q + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

    // FIFO storage carries no reset; only the pointers and count matter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= nonce_in;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Next-state logic; the serializer is the only consumer of the FIFO.
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: if (w_nonempty) begin
                state_d = S_HDR;
                w_pop   = 1'b1;
            end
            S_HDR: if (w_accept) state_d = S_B3;
            S_B3:  if (w_accept) state_d = S_B2;
            S_B2:  if (w_accept) state_d = S_B1;
            S_B1:  if (w_accept) state_d = S_B0;
            S_B0: if (w_accept) begin
                // Chain straight into the next record with no idle beat.
                if (w_nonempty) begin
                    state_d = S_HDR;
                    w_pop   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the byte for the upcoming state is registered so that
    // out_data/out_valid hold steady during backpressure.
    always_comb begin
        shreg_d = w_pop ? mem_q[rd_ptr_q] : shreg_q;
        out_valid_d = (state_d != S_IDLE);
        case (state_d)
            S_HDR:   out_data_d = SYNC_BYTE;
            S_B3:    out_data_d = shreg_d[31:24];
            S_B2:    out_data_d = shreg_d[23:16];
            S_B1:    out_data_d = shreg_d[15:8];
            S_B0:    out_data_d = shreg_d[7:0];
            default: out_data_d = 8'h00;
        endcase
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = w_nonempty || (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire
